// File: rtl/nx1_cgarb_pkg.sv
// Shared encodings for the character-generator ROM arbiter: owner tags,
// CPU read FSM states and the CG address width.
package nx1_cgarb_pkg;

    localparam int unsigned CG_AW = 11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } cpu_state_t;

endpackage

// File: rtl/nx1_cgarb.sv
// CG ROM port arbiter: video font fetches take strict priority, CPU reads
// are served in video-free cycles through a 4-phase req/ack handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no CPU read outstanding; may be granted when video is idle
// ST_ISSUE | CPU read in the ROM pipeline, waiting for its capture edge
// ST_DONE  | CPU_DATA valid, CPU_ACK high until CPU_REQ falls
module nx1_cgarb
    import nx1_cgarb_pkg::*;
#(
    parameter int unsigned def_MAXWAIT = 63
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VID_REQ,
    input  logic [CG_AW-1:0] VID_ADDR,
    output logic             VID_VALID,
    output logic [7:0]       VID_DATA,
    input  logic             CPU_REQ,
    input  logic [CG_AW-1:0] CPU_ADDR,
    output logic             CPU_ACK,
    output logic [7:0]       CPU_DATA,
    output logic [CG_AW-1:0] ROM_ADDR,
    input  logic [7:0]       ROM_DATA,
    output logic             STARVE
);

    localparam logic [7:0] MAXWAIT = 8'(def_MAXWAIT);

    cpu_state_t       state_q, state_d;
    owner_t           tag1_q, tag1_d;
    owner_t           tag2_q;
    logic [CG_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]       wait_q, wait_d;
    logic             starve_q, starve_d;
    logic             cancel_q, cancel_d;
    logic             vid_valid_q, vid_valid_d;
    logic [7:0]       vid_data_q, vid_data_d;
    logic [7:0]       cpu_data_q, cpu_data_d;
    logic             cpu_grant;

    // Grant and ROM address issue
    always_comb begin
        cpu_grant  = 1'b0;
        rom_addr_d = rom_addr_q;
        tag1_d     = OWN_NONE;
        if (VID_REQ) begin
            rom_addr_d = VID_ADDR;
            tag1_d     = OWN_VID;
        end else if (CPU_REQ && (state_q == ST_IDLE)) begin
            cpu_grant  = 1'b1;
            rom_addr_d = CPU_ADDR;
            tag1_d     = OWN_CPU;
        end
    end

    // Video capture: tag reaches stage 2 exactly when the ROM byte is ready
    always_comb begin
        vid_valid_d = 1'b0;
        vid_data_d  = vid_data_q;
        if (tag2_q == OWN_VID) begin
            vid_valid_d = 1'b1;
            vid_data_d  = ROM_DATA;
        end
    end

    // CPU read FSM; cancel_q remembers a CPU_REQ drop anywhere in ISSUE
    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        cpu_data_d = cpu_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_grant) begin
                    state_d  = ST_ISSUE;
                    cancel_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!CPU_REQ) begin
                    cancel_d = 1'b1;
                end
                if (tag2_q == OWN_CPU) begin
                    if (cancel_q || !CPU_REQ) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DONE;
                        cpu_data_d = ROM_DATA;
                    end
                end
            end
            ST_DONE: begin
                if (!CPU_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Starvation watch: counts only cycles the CPU is blocked by video
    always_comb begin
        wait_d = wait_q;
        if (cpu_grant || !CPU_REQ) begin
            wait_d = 8'd0;
        end else if ((state_q == ST_IDLE) && VID_REQ && (wait_q != MAXWAIT)) begin
            wait_d = wait_q + 8'd1;
        end
        starve_d = starve_q | (wait_d == MAXWAIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tag1_q      <= OWN_NONE;
            tag2_q      <= OWN_NONE;
            rom_addr_q  <= '0;
            wait_q      <= 8'd0;
            starve_q    <= 1'b0;
            cancel_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= 8'd0;
            cpu_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            rom_addr_q  <= rom_addr_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            cancel_q    <= cancel_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    assign VID_VALID = vid_valid_q;
    assign VID_DATA  = vid_data_q;
    assign CPU_ACK   = (state_q == ST_DONE);
    assign CPU_DATA  = cpu_data_q;
    assign ROM_ADDR  = rom_addr_q;
    assign STARVE    = starve_q;

endmodule

// File: tb/tb_nx1_cgarb.sv
// Directed bench for nx1_cgarb with a synchronous 1-clock-latency CG ROM model.
module tb_nx1_cgarb;

    logic        CLK;
    logic        RST;
    logic        VID_REQ;
    logic [10:0] VID_ADDR;
    logic        VID_VALID;
    logic [7:0]  VID_DATA;
    logic        CPU_REQ;
    logic [10:0] CPU_ADDR;
    logic        CPU_ACK;
    logic [7:0]  CPU_DATA;
    logic [10:0] ROM_ADDR;
    logic [7:0]  ROM_DATA;
    logic        STARVE;

    int n_assert = 0;
    int n_fail   = 0;

    nx1_cgarb #(.def_MAXWAIT(63)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .VID_REQ   (VID_REQ),
        .VID_ADDR  (VID_ADDR),
        .VID_VALID (VID_VALID),
        .VID_DATA  (VID_DATA),
        .CPU_REQ   (CPU_REQ),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_ACK   (CPU_ACK),
        .CPU_DATA  (CPU_DATA),
        .ROM_ADDR  (ROM_ADDR),
        .ROM_DATA  (ROM_DATA),
        .STARVE    (STARVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110} ^ 8'h5A;
    endfunction

    always @(posedge CLK) ROM_DATA <= rom_fn(ROM_ADDR);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; VID_REQ = 1'b0; VID_ADDR = '0; CPU_REQ = 1'b0; CPU_ADDR = '0;
        tick(); tick();
        chk("rst_vid_valid", 32'(VID_VALID), 0);
        chk("rst_cpu_ack",   32'(CPU_ACK), 0);
        chk("rst_rom_addr",  32'(ROM_ADDR), 0);
        chk("rst_starve",    32'(STARVE), 0);
        chk("rst_vid_data",  32'(VID_DATA), 0);
        chk("rst_cpu_data",  32'(CPU_DATA), 0);
        RST = 1'b0;
        tick();

        // single video fetch
        VID_REQ = 1'b1; VID_ADDR = 11'h041;
        tick();
        VID_REQ = 1'b0;
        chk("v1_rom_addr", 32'(ROM_ADDR), 32'h041);
        chk("v1_valid_t0", 32'(VID_VALID), 0);
        tick();
        chk("v1_valid_t1", 32'(VID_VALID), 0);
        tick();
        chk("v1_valid_t2", 32'(VID_VALID), 1);
        chk("v1_data", 32'(VID_DATA), 32'(rom_fn(11'h041)));
        tick();
        chk("v1_valid_end", 32'(VID_VALID), 0);
        chk("v1_data_hold", 32'(VID_DATA), 32'(rom_fn(11'h041)));
        chk("v1_rom_hold", 32'(ROM_ADDR), 32'h041);

        // video burst 0x100..0x107
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) begin
                VID_REQ = 1'b1; VID_ADDR = 11'(11'h100 + k - 1);
            end else begin
                VID_REQ = 1'b0;
            end
            tick();
            chk($sformatf("burst_valid_%0d", k), 32'(VID_VALID), (k >= 3 && k <= 10) ? 1 : 0);
            if (k >= 3 && k <= 10)
                chk($sformatf("burst_data_%0d", k), 32'(VID_DATA), 32'(rom_fn(11'(11'h100 + k - 3))));
        end

        // CPU read, video idle
        CPU_REQ = 1'b1; CPU_ADDR = 11'h7FF;
        tick();
        chk("c1_rom_addr", 32'(ROM_ADDR), 32'h7FF);
        chk("c1_ack_t0", 32'(CPU_ACK), 0);
        tick();
        chk("c1_ack_t1", 32'(CPU_ACK), 0);
        tick();
        chk("c1_ack_t2", 32'(CPU_ACK), 1);
        chk("c1_data", 32'(CPU_DATA), 32'(rom_fn(11'h7FF)));
        tick();
        chk("c1_ack_held", 32'(CPU_ACK), 1);
        CPU_REQ = 1'b0;
        tick();
        chk("c1_ack_drop", 32'(CPU_ACK), 0);
        tick();
        chk("c1_rom_hold", 32'(ROM_ADDR), 32'h7FF);

        // starvation: video held 70 clocks
        CPU_REQ = 1'b1; CPU_ADDR = 11'h123;
        VID_REQ = 1'b1; VID_ADDR = 11'h200;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 62) chk("starve_62", 32'(STARVE), 0);
            if (k == 63) chk("starve_63", 32'(STARVE), 1);
            if (k == 70) chk("starve_ack_blocked", 32'(CPU_ACK), 0);
        end
        chk("starve_rom_vid", 32'(ROM_ADDR), 32'h200);
        VID_REQ = 1'b0;
        tick();
        chk("starve_cpu_grant", 32'(ROM_ADDR), 32'h123);
        tick();
        chk("starve_ack_t1", 32'(CPU_ACK), 0);
        tick();
        chk("starve_ack", 32'(CPU_ACK), 1);
        chk("starve_cpu_data", 32'(CPU_DATA), 32'(rom_fn(11'h123)));
        chk("starve_sticky", 32'(STARVE), 1);
        CPU_REQ = 1'b0;
        tick();
        chk("starve_ack_drop", 32'(CPU_ACK), 0);

        // CPU abort one clock after grant
        CPU_REQ = 1'b1; CPU_ADDR = 11'h055;
        tick();
        CPU_REQ = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("abort_ack_%0d", k), 32'(CPU_ACK), 0);
        end
        chk("abort_data_kept", 32'(CPU_DATA), 32'(rom_fn(11'h123)));
        CPU_REQ = 1'b1; CPU_ADDR = 11'h066;
        tick(); tick();
        chk("retry_ack_t1", 32'(CPU_ACK), 0);
        tick();
        chk("retry_ack", 32'(CPU_ACK), 1);
        chk("retry_data", 32'(CPU_DATA), 32'(rom_fn(11'h066)));
        CPU_REQ = 1'b0;
        tick();
        chk("retry_ack_drop", 32'(CPU_ACK), 0);
        chk("starve_still", 32'(STARVE), 1);

        // reset with reads in flight
        VID_REQ = 1'b1; VID_ADDR = 11'h0AA;
        tick();
        VID_REQ = 1'b0; CPU_REQ = 1'b1; CPU_ADDR = 11'h0BB;
        tick();
        chk("rr_rom_cpu", 32'(ROM_ADDR), 32'h0BB);
        RST = 1'b1; CPU_REQ = 1'b0;
        tick();
        RST = 1'b0;
        chk("rr_rom_addr", 32'(ROM_ADDR), 0);
        chk("rr_starve",   32'(STARVE), 0);
        chk("rr_vid_data", 32'(VID_DATA), 0);
        chk("rr_cpu_data", 32'(CPU_DATA), 0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("rr_vid_valid_%0d", k), 32'(VID_VALID), 0);
            chk($sformatf("rr_cpu_ack_%0d", k), 32'(CPU_ACK), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nx1_cgarb.md
NX1_CGARB -- requirements
Module: nx1_cgarb

Interface
REQ-001 Parameter def_MAXWAIT, default 63: CPU wait-cycle threshold for the starvation flag (range 1..255).
REQ-002 CLK  in  1  single system clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 VID_REQ  in  1  video (CRTC) font fetch request, one beat per asserted cycle.
REQ-005 VID_ADDR  in  11  video fetch address: code*8+raster.
REQ-006 VID_VALID  out  1  one-cycle pulse, VID_DATA valid.
REQ-007 VID_DATA  out  8  video font byte.
REQ-008 CPU_REQ  in  1  CPU CG read request, level, 4-phase handshake.
REQ-009 CPU_ADDR  in  11  CPU read address, stable while CPU_REQ=1.
REQ-010 CPU_ACK  out  1  CPU read complete; held until CPU_REQ falls.
REQ-011 CPU_DATA  out  8  CPU font byte, valid while CPU_ACK=1.
REQ-012 ROM_ADDR  out  11  registered address to one CG ROM port (synchronous read, 1-clock latency).
REQ-013 ROM_DATA  in  8  CG ROM read data.
REQ-014 STARVE  out  1  sticky flag: CPU waited def_MAXWAIT cycles.

Function
REQ-015 Grant each cycle: VID_REQ=1 wins unconditionally; CPU granted only if VID_REQ=0 and CPU FSM in IDLE with CPU_REQ=1.
REQ-016 On grant at edge T: ROM_ADDR loads granted address at T; owner tag (NONE/VID/CPU) enters a 2-stage pipeline; ROM_DATA captured at edge T+2.
REQ-017 Video latency fixed: VID_VALID=1 for exactly the cycle after edge T+2, VID_DATA=ROM byte for VID_ADDR; back-to-back VID_REQ gives back-to-back VID_VALID, throughput 1/clock.
REQ-018 VID_DATA holds last value when VID_VALID=0.
REQ-019 CPU FSM states: IDLE, ISSUE, DONE.
REQ-020 IDLE->ISSUE on CPU grant; ISSUE->DONE at the edge capturing the CPU tag (CPU_DATA loaded, CPU_ACK=1 from next cycle); DONE->IDLE at the first edge with CPU_REQ=0 (CPU_ACK=0 from next cycle).
REQ-021 CPU_REQ falling during ISSUE: read completes, data discarded, no CPU_ACK, FSM returns to IDLE at capture edge.
REQ-022 A new CPU grant requires CPU_REQ low for at least one cycle after CPU_ACK (no re-grant while in DONE).
REQ-023 Wait counter, 8 bits: clears on grant or CPU_REQ=0; increments each cycle CPU_REQ=1, FSM=IDLE, and VID_REQ=1; saturates at def_MAXWAIT.
REQ-024 STARVE sets when the counter reaches def_MAXWAIT; clears only by RST.
REQ-025 Simultaneous VID_REQ and CPU_REQ: video issued; CPU issued in the first cycle with VID_REQ=0.
REQ-026 ROM_ADDR holds its last value when nothing is granted.

Reset
REQ-027 RST=1: FSM=IDLE, pipeline tags=NONE, wait counter=0, VID_VALID=0, CPU_ACK=0, STARVE=0, VID_DATA=0, CPU_DATA=0, ROM_ADDR=0.
REQ-028 RST mid-operation discards in-flight reads; no VID_VALID or CPU_ACK is produced for them after RST falls.

Structure
REQ-029 Shared package holds the owner tag encoding (NONE=0, VID=1, CPU=2), the CPU FSM state encoding, and the CG address width constant (11).
REQ-030 Single module, no sub-modules; the CG ROM instance lives in the parent, not in this block.

Verification
REQ-031 Single VID_REQ, addr 0x041 -> VID_VALID pulse 2 clocks later, VID_DATA=ROM[0x041].
REQ-032 VID_REQ held 8 clocks, addr 0x100..0x107 -> 8 consecutive VID_VALID beats, data ROM[0x100..0x107] in order.
REQ-033 CPU_REQ addr 0x7FF, video idle -> CPU_ACK 3 clocks after request, CPU_DATA=ROM[0x7FF]; CPU_REQ drop -> CPU_ACK low next cycle.
REQ-034 CPU_REQ with VID_REQ held 70 clocks, def_MAXWAIT=63 -> STARVE=1 at cycle 63; CPU served in first video-free cycle; STARVE stays 1.
REQ-035 CPU_REQ dropped 1 clock after grant -> no CPU_ACK; next CPU_REQ served normally.
REQ-036 RST pulse one clock after VID_REQ and CPU grant -> no VID_VALID/CPU_ACK; all outputs at reset values.
